fetch_controller: RTL and testbench
===================================

// Module: fetch_controller
//
// PURPOSE
//   Sequences the byte-addressed, big-endian instruction memory for the single-cycle core.
//   - Owns the program counter and drives the memory read address combinationally from it.
//   - Captures each returned word into an IF output register with a valid flag.
//   - Applies stall and branch/jump redirect requests from downstream.
//   - Stops on a halt word or an illegal fetch address.
//
// PARAMETERS
//   RESET_PC   32'h0000_0000  byte address of the first fetch after reset
//   MEM_WORDS  256            instruction memory depth in 32-bit words; legal PC < MEM_WORDS*4
//   HALT_WORD  32'hFFFF_FFFF  instruction encoding that stops fetching
//
// PORTS
//   clk              input   1   clock; all state updates on posedge
//   reset            input   1   asynchronous, active-low reset
//   stall            input   1   hold PC and IF register this cycle
//   redirect_valid   input   1   load redirect_target into PC; flush IF
//   redirect_target  input   32  new PC (byte address)
//   imem_address     output  32  read address to instruction memory (= pc)
//   imem_instruction input   32  word returned combinationally by instruction memory
//   pc               output  32  current fetch PC
//   if_instruction   output  32  registered fetched instruction
//   if_pc            output  32  PC of if_instruction
//   if_valid         output  1   if_instruction/if_pc hold a live instruction
//   halted           output  1   HALT_WORD was fetched; fetching stopped
//   fault            output  1   illegal fetch address; fetching stopped
//
// BEHAVIOUR
//   Reset (reset==0, any time, asynchronous)
//     - pc=RESET_PC; if_instruction=0; if_pc=0; if_valid=0; halted=0; fault=0; state=BOOT.
//   imem_address = pc, combinational, in every state.
//   States
//     BOOT  - Fixed one-cycle wait after reset release: memory contents settle, nothing is fetched.
//           - if_valid=0; -> RUN unconditionally on the next posedge.
//     RUN   - Each posedge applies the first matching rule, highest priority first:
//       1 redirect_valid: pc<=redirect_target; if_valid<=0. Redirect beats stall.
//       2 stall: pc, if_* and state all hold.
//       3 illegal pc (pc[1:0]!=0 or pc>=MEM_WORDS*4): fault<=1; if_valid<=0; pc holds; -> FAULT.
//       4 imem_instruction==HALT_WORD: halted<=1; if_valid<=0; pc holds; -> HALT.
//       5 otherwise: if_instruction<=imem_instruction; if_pc<=pc; if_valid<=1; pc<=pc+4.
//     HALT  - Terminal until reset.
//           - pc, if_instruction and if_pc hold; if_valid=0.
//           - stall and redirect are ignored.
//     FAULT - Same as HALT, with fault=1.
//   Arithmetic and checks
//     - pc+4 is 32-bit modulo; wrap to 0 is never reached because the range check trips first.
//   Boundary conditions
//     - Last legal word (pc=MEM_WORDS*4-4) fetches normally.
//     - The following cycle faults.
//     - A misaligned redirect_target is accepted into pc and faults on the next RUN cycle
//       that is not stalled or redirected.
//     - redirect_valid together with an illegal current pc: the redirect wins, no fault.
//     - The halt check uses the word at the current pc only; a redirect in the same cycle
//       suppresses the halt.
//     - Reset asserted mid-RUN clears if_valid immediately, asynchronously.
//   Status outputs
//     - halted and fault are mutually exclusive.
//     - Both are sticky until reset.
//
// TESTING
//   1 Reset release, memory words 0..3 = 11,22,33,44 -> BOOT 1 cycle if_valid=0;
//     then if_pc=0,4,8 with if_instruction=11,22,33 on consecutive cycles.
//   2 stall=1 for 3 cycles while pc=8 -> pc stays 8; if_instruction/if_pc/if_valid unchanged;
//     resumes at 8 when stall drops.
//   3 At pc=12: redirect_valid=1, target=32, stall=1 -> next cycle pc=32, if_valid=0;
//     following cycle if_pc=32.
//   4 Word at 40 = 32'hFFFF_FFFF -> after fetching 36: halted=1, if_valid=0, pc=40;
//     redirect to 0 is ignored.
//   5 Redirect to 32'd6 -> next RUN cycle fault=1, pc=6, if_valid=0.
//     Separately, MEM_WORDS=4 with sequential run faults at pc=16.
//   6 Drop reset mid-run at pc=20 -> outputs clear asynchronously;
//     after release: BOOT, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses the big-endian instruction memory,
// registers each fetched word with a valid flag, and stops on a halt word or an illegal address.
module fetch_controller #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 256,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic [31:0] pc,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT,
      ST_FAULT
   } state_t;

   // First byte address past the end of instruction memory.
   localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instruction_q, if_instruction_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        if_valid_q, if_valid_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;
   logic        pc_illegal;

   assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);

   // NOTE: every signal assigned here gets its hold value first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      if_instruction_d = if_instruction_q;
      if_pc_d          = if_pc_q;
      if_valid_d       = if_valid_q;
      halted_d         = halted_q;
      fault_d          = fault_q;

      case (state_q)
         ST_BOOT: begin
            if_valid_d = 1'b0;
            state_d    = ST_RUN;
         end

         ST_RUN: begin
            if (redirect_valid) begin
               // Redirect outranks stall, the range check and the halt check.
               pc_d       = redirect_target;
               if_valid_d = 1'b0;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (pc_illegal) begin
               fault_d    = 1'b1;
               if_valid_d = 1'b0;
               state_d    = ST_FAULT;
            end else if (imem_instruction == HALT_WORD) begin
               halted_d   = 1'b1;
               if_valid_d = 1'b0;
               state_d    = ST_HALT;
            end else begin
               if_instruction_d = imem_instruction;
               if_pc_d          = pc_q;
               if_valid_d       = 1'b1;
               pc_d             = pc_q + 32'd4;
            end
         end

         ST_HALT, ST_FAULT: begin
            // Terminal until reset; stall and redirect have no effect.
            if_valid_d = 1'b0;
         end

         default: begin
            state_d    = ST_BOOT;
            if_valid_d = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_BOOT;
         pc_q             <= RESET_PC;
         if_instruction_q <= 32'h0;
         if_pc_q          <= 32'h0;
         if_valid_q       <= 1'b0;
         halted_q         <= 1'b0;
         fault_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         if_instruction_q <= if_instruction_d;
         if_pc_q          <= if_pc_d;
         if_valid_q       <= if_valid_d;
         halted_q         <= halted_d;
         fault_q          <= fault_d;
      end
   end

   assign imem_address   = pc_q;
   assign pc             = pc_q;
   assign if_instruction = if_instruction_q;
   assign if_pc          = if_pc_q;
   assign if_valid       = if_valid_q;
   assign halted         = halted_q;
   assign fault          = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table for the main fetch/stall/redirect/halt
// flow, plus hand-written sequences for reset, fault and memory-boundary corners.
module tb_fetch_controller;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] imem_address;
   logic [31:0] imem_instruction;
   logic [31:0] pc;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        halted;
   logic        fault;

   // Small-memory instance (MEM_WORDS=4) for the end-of-memory boundary.
   logic        reset_s;
   logic        stall_s;
   logic        redirect_valid_s;
   logic [31:0] redirect_target_s;
   logic [31:0] imem_address_s;
   logic [31:0] imem_instruction_s;
   logic [31:0] pc_s;
   logic [31:0] if_instruction_s;
   logic [31:0] if_pc_s;
   logic        if_valid_s;
   logic        halted_s;
   logic        fault_s;

   logic [31:0] mem   [256];
   logic [31:0] mem_s [4];

   int checks = 0;
   int errors = 0;

   fetch_controller dut (
      .clk              (clk),
      .reset            (reset),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .imem_address     (imem_address),
      .imem_instruction (imem_instruction),
      .pc               (pc),
      .if_instruction   (if_instruction),
      .if_pc            (if_pc),
      .if_valid         (if_valid),
      .halted           (halted),
      .fault            (fault)
   );

   fetch_controller #(.MEM_WORDS(4)) dut_small (
      .clk              (clk),
      .reset            (reset_s),
      .stall            (stall_s),
      .redirect_valid   (redirect_valid_s),
      .redirect_target  (redirect_target_s),
      .imem_address     (imem_address_s),
      .imem_instruction (imem_instruction_s),
      .pc               (pc_s),
      .if_instruction   (if_instruction_s),
      .if_pc            (if_pc_s),
      .if_valid         (if_valid_s),
      .halted           (halted_s),
      .fault            (fault_s)
   );

   assign imem_instruction   = (imem_address < 32'd1024) ? mem[imem_address[9:2]] : 32'h0;
   assign imem_instruction_s = (imem_address_s < 32'd16) ? mem_s[imem_address_s[3:2]] : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rt;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_if_pc;
      logic [31:0] e_inst;
      logic        e_halted;
      logic        e_fault;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_if_pc, input logic [31:0] e_inst,
                              input logic e_halted, input logic e_fault);
      check({tag, " pc"}, pc, e_pc);
      check({tag, " if_valid"}, 32'(if_valid), 32'(e_valid));
      check({tag, " if_pc"}, if_pc, e_if_pc);
      check({tag, " if_instruction"}, if_instruction, e_inst);
      check({tag, " halted"}, 32'(halted), 32'(e_halted));
      check({tag, " fault"}, 32'(fault), 32'(e_fault));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("async reset pc", pc, 32'h0);
      check("async reset if_valid", 32'(if_valid), 32'h0);
      check("async reset halted", 32'(halted), 32'h0);
      check("async reset fault", 32'(fault), 32'h0);
      tick();
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd100 + 32'(i);
      mem[0]  = 32'd11;
      mem[1]  = 32'd22;
      mem[2]  = 32'd33;
      mem[3]  = 32'd44;
      mem[10] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) mem_s[i] = 32'hA0 + 32'(i);

      //          stall rv  rt     pc    v  if_pc inst   h  f
      vecs[0]  = '{1'b0, 1'b0, 32'd0,  32'd0,  1'b0, 32'd0,  32'd0,   1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'd0,  32'd4,  1'b1, 32'd0,  32'd11,  1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'd0,  32'd8,  1'b1, 32'd4,  32'd22,  1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'd0,  32'd8,  1'b1, 32'd4,  32'd22,  1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'd0,  32'd8,  1'b1, 32'd4,  32'd22,  1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'd0,  32'd8,  1'b1, 32'd4,  32'd22,  1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'd0,  32'd12, 1'b1, 32'd8,  32'd33,  1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'd32, 32'd32, 1'b0, 32'd8,  32'd33,  1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'd0,  32'd36, 1'b1, 32'd32, 32'd108, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'd0,  32'd40, 1'b1, 32'd36, 32'd109, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'd0,  32'd40, 1'b0, 32'd36, 32'd109, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'd0,  32'd40, 1'b0, 32'd36, 32'd109, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'd0,  32'd40, 1'b0, 32'd36, 32'd109, 1'b1, 1'b0};

      reset             = 1'b0;
      reset_s           = 1'b0;
      stall             = 1'b0;
      redirect_valid    = 1'b0;
      redirect_target   = 32'h0;
      stall_s           = 1'b0;
      redirect_valid_s  = 1'b0;
      redirect_target_s = 32'h0;

      tick();
      tick();
      check_state("reset", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;

      // Boot, sequential fetch, stall, redirect-beats-stall, halt and ignored redirect.
      for (int i = 0; i < 13; i++) begin
         stall           = vecs[i].stall;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].rt;
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid,
                     vecs[i].e_if_pc, vecs[i].e_inst, vecs[i].e_halted, vecs[i].e_fault);
      end
      stall          = 1'b0;
      redirect_valid = 1'b0;

      // Reset out of HALT, then run to pc=20 and pull reset between edges.
      do_reset();
      tick();
      check_state("boot2", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check_state("run to 20", 32'd20, 1'b1, 32'd16, 32'd104, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check_state("mid-run reset", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_state("boot3", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      check_state("restart", 32'd4, 1'b1, 32'd0, 32'd11, 1'b0, 1'b0);

      // Misaligned redirect is accepted, then faults; redirects are ignored afterwards.
      redirect_valid  = 1'b1;
      redirect_target = 32'd6;
      tick();
      redirect_valid = 1'b0;
      check_state("misaligned redirect", 32'd6, 1'b0, 32'd0, 32'd11, 1'b0, 1'b0);
      tick();
      check_state("misaligned fault", 32'd6, 1'b0, 32'd0, 32'd11, 1'b0, 1'b1);
      redirect_valid  = 1'b1;
      redirect_target = 32'd0;
      tick();
      redirect_valid = 1'b0;
      check_state("fault sticky", 32'd6, 1'b0, 32'd0, 32'd11, 1'b0, 1'b1);

      // Redirect rescues an illegal pc, and suppresses a halt at the current pc.
      do_reset();
      tick();
      redirect_valid  = 1'b1;
      redirect_target = 32'd6;
      tick();
      check("to illegal pc", pc, 32'd6);
      redirect_target = 32'd0;
      tick();
      check_state("redirect beats fault", 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      redirect_target = 32'd40;
      tick();
      check("to halt word pc", pc, 32'd40);
      redirect_target = 32'd12;
      tick();
      check_state("redirect beats halt", 32'd12, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      redirect_valid = 1'b0;
      tick();
      check_state("after halt skip", 32'd16, 1'b1, 32'd12, 32'd44, 1'b0, 1'b0);

      // Four-word memory: last legal word fetches, the next address faults.
      reset_s = 1'b1;
      tick();
      check("small boot pc", pc_s, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("small last pc", pc_s, 32'd16);
      check("small last if_pc", if_pc_s, 32'd12);
      check("small last inst", if_instruction_s, 32'hA3);
      check("small last valid", 32'(if_valid_s), 32'd1);
      check("small last fault", 32'(fault_s), 32'd0);
      tick();
      check("small fault", 32'(fault_s), 32'd1);
      check("small fault pc", pc_s, 32'd16);
      check("small fault valid", 32'(if_valid_s), 32'd0);
      check("small fault if_pc", if_pc_s, 32'd12);
      check("small halted", 32'(halted_s), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
